// File: rtl/data_sram_responder_if.sv
// ----------------------------------------------------------------------------
// data_sram_responder_if
//   CPU data-side SRAM port bundle between the MiniMIPS32 data port (master)
//   and the data RAM / device responder (slave).
//   dce    master->slave  data access enable
//   we     master->slave  byte write enables, 0 = read
//   daddr  master->slave  byte address (bits [1:0] ignored)
//   din    master->slave  write data
//   dm     slave->master  registered read data
// ----------------------------------------------------------------------------
interface data_sram_responder_if;
   logic        dce;
   logic [3:0]  we;
   logic [31:0] daddr;
   logic [31:0] din;
   logic [31:0] dm;

   modport master (output dce, output we, output daddr, output din, input dm);
   modport slave  (input dce, input we, input daddr, input din, output dm);
endinterface

// File: rtl/data_sram_responder.sv
// ----------------------------------------------------------------------------
// data_sram_responder
//   Responder for the CPU data-side SRAM port. Serves a word-addressed data RAM
//   (byte-lane writes, 1-cycle registered read) plus a device region selected
//   by daddr[31:16] == DEV_BASE holding LED, SWITCH and an optional timer.
//
//   Ports:
//     cpu_clk_50M  clock, all state on rising edge
//     cpu_rst      synchronous active-high reset
//     bus          data port (slave modport): dce, we, daddr, din -> dm
//     sw_i         switch levels (read via SWITCH register)
//     led_o        LED register
//     timer_int_o  timer interrupt level (= pending flag)
//
//   Build option: define DSRAM_TIMER_EN to implement COUNT/COMPARE/CTRL at
//   offsets 0xE000/0xE004/0xE008. Without it those offsets read 0, writes are
//   dropped and timer_int_o is tied low.
// ----------------------------------------------------------------------------
module data_sram_responder #(
   parameter int          ADDR_W   = 14,
   parameter int          LED_W    = 16,
   parameter int          SW_W     = 8,
   parameter logic [15:0] DEV_BASE = 16'hBFAF
) (
   input  logic                 cpu_clk_50M,
   input  logic                 cpu_rst,
   data_sram_responder_if.slave bus,
   input  logic [SW_W-1:0]      sw_i,
   output logic [LED_W-1:0]     led_o,
   output logic                 timer_int_o
);
   localparam int          DEPTH       = 1 << ADDR_W;
   localparam logic [15:0] OFF_LED     = 16'h0000;
   localparam logic [15:0] OFF_SW      = 16'h0004;
   localparam logic [15:0] OFF_COUNT   = 16'hE000;
   localparam logic [15:0] OFF_COMPARE = 16'hE004;
   localparam logic [15:0] OFF_CTRL    = 16'hE008;

   // Replace the byte lanes of old_val selected by be with new_val.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
      return r;
   endfunction

   // ---------------- decode ----------------
   logic              dev_sel;
   logic [ADDR_W-1:0] ram_idx;
   logic [15:0]       dev_off;
   logic              rd_en, wr_en;
   logic              ram_rd, ram_wr, dev_rd, dev_wr;
   logic [1:0]        unused_addr_bits;

   assign dev_sel = (bus.daddr[31:16] == DEV_BASE);
   assign ram_idx = bus.daddr[ADDR_W+1:2];   // upper bits alias modulo depth
   assign dev_off = bus.daddr[15:0];
   assign rd_en   = bus.dce && (bus.we == 4'b0000);
   assign wr_en   = bus.dce && (bus.we != 4'b0000);
   assign ram_rd  = rd_en && !dev_sel;
   assign ram_wr  = wr_en && !dev_sel;
   assign dev_rd  = rd_en && dev_sel;
   assign dev_wr  = wr_en && dev_sel;
   assign unused_addr_bits = bus.daddr[1:0];

   // ---------------- data RAM: one byte-wide array per lane ----------------
   logic [31:0] ram_q;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] q_reg;

         always_ff @(posedge cpu_clk_50M) begin
            if (cpu_rst) begin
               q_reg <= 8'h00;
            end else begin
               if (ram_wr && bus.we[gi])
                  mem[ram_idx] <= bus.din[8*gi +: 8];
               // Reads and writes are exclusive, so read-after-write in the
               // following cycle sees the freshly written byte.
               if (ram_rd)
                  q_reg <= mem[ram_idx];
            end
         end

         assign ram_q[8*gi +: 8] = q_reg;
      end
   endgenerate

   // ---------------- device registers ----------------
   logic [LED_W-1:0] led_reg, led_next;
   logic [31:0]      led_ext, sw_ext, dev_rdata;
   logic [31:0]      dev_q_reg;
   logic             rd_dev_reg;   // last read targeted the device region

`ifdef DSRAM_TIMER_EN
   logic [31:0] count_reg, count_next;
   logic [31:0] compare_reg, compare_next;
   logic        enable_reg, enable_next;
   logic        pending_reg, pending_next;
`endif

   always_comb begin
      led_ext = '0;
      led_ext[LED_W-1:0] = led_reg;
      sw_ext = '0;
      sw_ext[SW_W-1:0] = sw_i;

      dev_rdata = 32'h0;
      case (dev_off)
         OFF_LED:     dev_rdata = led_ext;
         OFF_SW:      dev_rdata = sw_ext;
`ifdef DSRAM_TIMER_EN
         OFF_COUNT:   dev_rdata = count_reg;
         OFF_COMPARE: dev_rdata = compare_reg;
         OFF_CTRL:    dev_rdata = {30'h0, pending_reg, enable_reg};
`endif
         default:     dev_rdata = 32'h0;
      endcase
   end

   always_comb begin
      led_next = led_reg;
      if (dev_wr && dev_off == OFF_LED)
         led_next = LED_W'(merge_bytes(led_ext, bus.din, bus.we));
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         led_reg    <= '0;
         dev_q_reg  <= 32'h0;
         rd_dev_reg <= 1'b0;
      end else begin
         led_reg <= led_next;
         if (rd_en) begin
            rd_dev_reg <= dev_sel;
            if (dev_rd) dev_q_reg <= dev_rdata;
         end
      end
   end

   assign bus.dm = rd_dev_reg ? dev_q_reg : ram_q;
   assign led_o  = led_reg;

   // ---------------- timer ----------------
`ifdef DSRAM_TIMER_EN
   always_comb begin
      count_next   = count_reg;
      compare_next = compare_reg;
      enable_next  = enable_reg;
      pending_next = pending_reg;

      if (enable_reg)
         count_next = count_reg + 32'd1;
      // A CPU write to COUNT overrides the increment in the same cycle.
      if (dev_wr && dev_off == OFF_COUNT)
         count_next = merge_bytes(count_reg, bus.din, bus.we);

      if (dev_wr && dev_off == OFF_COMPARE) begin
         compare_next = merge_bytes(compare_reg, bus.din, bus.we);
         pending_next = 1'b0;
      end

      if (dev_wr && dev_off == OFF_CTRL && bus.we[0]) begin
         enable_next = bus.din[0];
         if (bus.din[1]) pending_next = 1'b0;
      end

      // Match set is evaluated last so it wins over any clear this cycle.
      if (enable_reg && count_reg == compare_reg)
         pending_next = 1'b1;
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         count_reg   <= 32'h0;
         compare_reg <= 32'h0;
         enable_reg  <= 1'b0;
         pending_reg <= 1'b0;
      end else begin
         count_reg   <= count_next;
         compare_reg <= compare_next;
         enable_reg  <= enable_next;
         pending_reg <= pending_next;
      end
   end

   assign timer_int_o = pending_reg;
`else
   assign timer_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
   logic        clk;
   logic        rst;
   logic [7:0]  sw;
   logic [15:0] led;
   logic        tint;
   logic [31:0] rd;
   int          total;
   int          bad;

   data_sram_responder_if bus ();

   data_sram_responder #(
      .ADDR_W(14), .LED_W(16), .SW_W(8), .DEV_BASE(16'hBFAF)
   ) dut (
      .cpu_clk_50M(clk),
      .cpu_rst    (rst),
      .bus        (bus),
      .sw_i       (sw),
      .led_o      (led),
      .timer_int_o(tint)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Each access task starts at a negedge, lets one posedge act on the
   // request, and returns at the following negedge with the bus idle.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.dce = 1'b1; bus.we = be; bus.daddr = a; bus.din = d;
      @(negedge clk);
      bus.dce = 1'b0; bus.we = 4'h0;
      $display("write addr=%h data=%h we=%b", a, d, be);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      bus.dce = 1'b1; bus.we = 4'h0; bus.daddr = a;
      @(negedge clk);
      bus.dce = 1'b0;
      d = bus.dm;
      $display("read  addr=%h dm=%h", a, d);
   endtask

   initial begin
      total = 0; bad = 0;
      bus.dce = 1'b0; bus.we = 4'h0; bus.daddr = 32'h0; bus.din = 32'h0;
      sw = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_dm",   bus.dm, 32'h0);
      check("rst_led",  {16'h0, led}, 32'h0);
      check("rst_tint", {31'h0, tint}, 32'h0);

      // full-word write / read back
      do_write(32'h0000_0010, 32'h1234_5678, 4'hF);
      do_read (32'h0000_0010, rd);
      check("ram_word", rd, 32'h1234_5678);

      // dm holds while idle and across a write
      @(negedge clk);
      check("dm_hold_idle", bus.dm, 32'h1234_5678);
      do_write(32'h0000_0030, 32'hDEAD_BEEF, 4'hF);
      check("dm_hold_write", bus.dm, 32'h1234_5678);

      // aliasing: bits above ADDR_W+1 ignored
      do_read(32'h0001_0010, rd);
      check("ram_alias", rd, 32'h1234_5678);

      // byte-lane write
      do_write(32'h0000_0020, 32'h1111_1111, 4'hF);
      do_write(32'h0000_0020, 32'hAABB_CCDD, 4'b0010);
      do_read (32'h0000_0020, rd);
      check("ram_lane1", rd, 32'h1111_CC11);

      // switch: read, write ignored
      sw = 8'hA5;
      do_read(32'hBFAF_0004, rd);
      check("sw_read", rd, 32'h0000_00A5);
      do_write(32'hBFAF_0004, 32'hFFFF_FFFF, 4'hF);
      do_read(32'hBFAF_0004, rd);
      check("sw_ro", rd, 32'h0000_00A5);

      // LED: upper bits read 0, byte enables honoured
      do_write(32'hBFAF_0000, 32'hFFFF_FFFF, 4'hF);
      check("led_full", {16'h0, led}, 32'h0000_FFFF);
      do_write(32'hBFAF_0000, 32'h0000_0012, 4'b0001);
      check("led_byte", {16'h0, led}, 32'h0000_FF12);
      do_read(32'hBFAF_0000, rd);
      check("led_read", rd, 32'h0000_FF12);

      // unmapped device offset
      do_write(32'hBFAF_0100, 32'h1234_5678, 4'hF);
      do_read (32'hBFAF_0100, rd);
      check("unmapped", rd, 32'h0);

      // device read then RAM read switches the dm source back
      do_read(32'h0000_0030, rd);
      check("ram_after_dev", rd, 32'hDEAD_BEEF);

`ifdef DSRAM_TIMER_EN
      // interrupt timing: COUNT=0 written at edge C, count reaches 5 after
      // C+5, pending sets at C+6
      do_write(32'hBFAF_E004, 32'd5, 4'hF);
      do_write(32'hBFAF_E008, 32'd1, 4'hF);
      do_write(32'hBFAF_E000, 32'd0, 4'hF);
      repeat (5) @(negedge clk);
      check("tint_before", {31'h0, tint}, 32'h0);
      @(negedge clk);
      check("tint_set", {31'h0, tint}, 32'h1);
      do_read(32'hBFAF_E008, rd);
      check("ctrl_pending", rd, 32'h3);
      do_write(32'hBFAF_E008, 32'd3, 4'hF);
      check("tint_w1c", {31'h0, tint}, 32'h0);
      do_read(32'hBFAF_E008, rd);
      check("ctrl_enable_kept", rd, 32'h1);

      // wrap: first read samples the written value, next sees the wrap
      do_write(32'hBFAF_E000, 32'hFFFF_FFFF, 4'hF);
      do_read (32'hBFAF_E000, rd);
      check("count_max", rd, 32'hFFFF_FFFF);
      do_read (32'hBFAF_E000, rd);
      check("count_wrap", rd, 32'h0);

      // arm an interrupt before the reset test
      do_write(32'hBFAF_E000, 32'd4, 4'hF);
      repeat (2) @(negedge clk);
      check("tint_rearm", {31'h0, tint}, 32'h1);
`else
      do_write(32'hBFAF_E000, 32'h0000_0055, 4'hF);
      do_read (32'hBFAF_E000, rd);
      check("count_absent", rd, 32'h0);
      do_write(32'hBFAF_E008, 32'h0000_0001, 4'hF);
      do_read (32'hBFAF_E008, rd);
      check("ctrl_absent", rd, 32'h0);
      check("tint_absent", {31'h0, tint}, 32'h0);
`endif

      // reset during an outstanding read
      do_read(32'h0000_0010, rd);
      check("pre_rst_dm", rd, 32'h1234_5678);
      bus.dce = 1'b1; bus.we = 4'h0; bus.daddr = 32'h0000_0020;
      rst = 1'b1;
      @(negedge clk);
      bus.dce = 1'b0;
      rst = 1'b0;
      $display("read  addr=%h under reset dm=%h", 32'h0000_0020, bus.dm);
      check("mid_rst_dm",   bus.dm, 32'h0);
      check("mid_rst_led",  {16'h0, led}, 32'h0);
      check("mid_rst_tint", {31'h0, tint}, 32'h0);

      // RAM contents survive reset
      do_read(32'h0000_0020, rd);
      check("ram_kept", rd, 32'h1111_CC11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
